// File: rtl/clk_en_gen_pkg.sv
// Shared types and constants for the clock-enable generator.
package clk_en_gen_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: wrap counter, active divisor and pending-divisor slot.
// Optional square-wave output when CLK_EN_GEN_SQ_EN is defined.
module clk_en_chan #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cnt_en,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
  output logic             ce,
  output logic             ack
`ifdef CLK_EN_GEN_SQ_EN
  ,
  output logic             sq
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend_val;
  logic             pend;
  logic             wrap;

  assign wrap = run && (cnt == div);
  assign ce   = wrap;
  // Outside RUN there is no phase to protect, so a pending divisor lands at once.
  assign ack  = pend && (!run || wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div      <= CNT_W'(DEF_DIV);
      pend_val <= '0;
      pend     <= 1'b0;
    end else begin
      if (!cnt_en || wrap) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
      if (ack) begin
        div  <= pend_val;
        pend <= 1'b0;
      end
      // A write on the apply cycle becomes the next pending value.
      if (wr) begin
        pend_val <= val;
        pend     <= 1'b1;
      end
    end
  end

`ifdef CLK_EN_GEN_SQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sq <= 1'b0;
    else if (!cnt_en) sq <= 1'b0;
    else if (ce)      sq <= ~sq;
  end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Lock-qualified reset sequencer plus NUM_CH programmable clock-enable channels.
// Define CLK_EN_GEN_SQ_EN to add the per-channel square-wave output sq.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int LOCK_WAIT = 16,
  parameter int DEF_DIV   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           locked,
  input  logic                           div_wr,
  input  logic [sel_width(NUM_CH)-1:0]   div_sel,
  input  logic [CNT_W-1:0]               div_val,
  output logic [NUM_CH-1:0]              div_ack,
  output logic [NUM_CH-1:0]              ce,
  output logic                           ready,
  output logic                           sys_rst
`ifdef CLK_EN_GEN_SQ_EN
  ,
  output logic [NUM_CH-1:0]              sq
`endif
);

  localparam int SEL_W = sel_width(NUM_CH);
  localparam int LW_W  = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  state_t                 state, state_nxt;
  logic [LW_W-1:0]        scnt, scnt_nxt;
  logic                   run;
  logic                   cnt_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], locked};
  end
  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    case (state)
      HOLD: begin
        state_nxt = WAIT_LOCK;
        scnt_nxt  = '0;
      end
      WAIT_LOCK: begin
        scnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          scnt_nxt  = '0;
        end else if (scnt == LW_W'(LOCK_WAIT - 1)) begin
          state_nxt = RUN;
          scnt_nxt  = '0;
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = HOLD;
    endcase
  end

  assign run     = (state == RUN);
  // Counters stop on the very edge that leaves RUN, so they restart from 0.
  assign cnt_en  = run && lock_s;
  assign ready   = run;
  assign sys_rst = ~run;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = div_wr && (div_sel == SEL_W'(i));
`ifdef CLK_EN_GEN_SQ_EN
    clk_en_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
      .clk(clk), .rst(rst), .run(run), .cnt_en(cnt_en), .wr(wr), .val(div_val),
      .ce(ce[i]), .ack(div_ack[i]), .sq(sq[i])
    );
`else
    clk_en_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_chan (
      .clk(clk), .rst(rst), .run(run), .cnt_en(cnt_en), .wr(wr), .val(div_val),
      .ce(ce[i]), .ack(div_ack[i])
    );
`endif
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen at default parameters (sq checks only with CLK_EN_GEN_SQ_EN).
module tb_clk_en_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic        div_wr;
  logic [1:0]  div_sel;
  logic [15:0] div_val;
  logic [3:0]  div_ack;
  logic [3:0]  ce;
  logic        ready;
  logic        sys_rst;
`ifdef CLK_EN_GEN_SQ_EN
  logic [3:0]  sq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_en_gen dut (
    .clk(clk), .rst(rst), .locked(locked), .div_wr(div_wr), .div_sel(div_sel),
    .div_val(div_val), .div_ack(div_ack), .ce(ce), .ready(ready), .sys_rst(sys_rst)
`ifdef CLK_EN_GEN_SQ_EN
    , .sq(sq)
`endif
  );

  task automatic do_reset(input logic lk);
    rst = 1'b1; locked = lk; div_wr = 1'b0; div_sel = 2'd0; div_val = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
    end
  endtask

  task automatic write_idle(input int ch, input logic [15:0] v);
    div_wr = 1'b1; div_sel = 2'(ch); div_val = v;
    @(negedge clk);
    div_wr = 1'b0;
    checks++;
    if (div_ack !== 4'(1 << ch)) begin
      failures++;
      $display("FAIL idle_ack ch%0d: div_ack=%b required %b", ch, div_ack, 4'(1 << ch));
    end
    @(negedge clk);
    checks++;
    if (div_ack !== 4'b0000) begin
      failures++;
      $display("FAIL idle_ack_clear ch%0d: div_ack=%b required 0000", ch, div_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; div_wr = 1'b0; div_sel = 2'd0; div_val = 16'd0;
    @(negedge clk);
    checks++;
    if ({ready, sys_rst, ce, div_ack} !== {1'b0, 1'b1, 4'b0, 4'b0}) begin
      failures++;
      $display("FAIL reset: ready=%b sys_rst=%b ce=%b ack=%b required 0 1 0000 0000",
               ready, sys_rst, ce, div_ack);
    end
  endtask

  task automatic test_lock_seq();
    do_reset(1'b1);
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      checks++;
      if (ready !== (n >= 19)) begin
        failures++;
        $display("FAIL lock_seq edge %0d: ready=%b required %b", n, ready, (n >= 19));
      end
    end
    checks++;
    if ({sys_rst, ce} !== {1'b0, 4'b1111}) begin
      failures++;
      $display("FAIL lock_seq_run: sys_rst=%b ce=%b required 0 1111", sys_rst, ce);
    end
  endtask

  task automatic test_glitch();
    do_reset(1'b1);
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      if (n == 11) locked = 1'b0;
      if (n == 12) locked = 1'b1;
      checks++;
      if (ready !== (n >= 31)) begin
        failures++;
        $display("FAIL glitch edge %0d: ready=%b required %b", n, ready, (n >= 31));
      end
    end
  endtask

  task automatic test_div();
    logic [3:0] exp;
    do_reset(1'b0);
    write_idle(0, 16'd0);
    write_idle(1, 16'd1);
    write_idle(2, 16'd3);
    write_idle(3, 16'd2);
    locked = 1'b1;
    wait_ready();
    for (int k = 0; k < 12; k++) begin
      exp = {(k % 3) == 2, (k % 4) == 3, (k % 2) == 1, 1'b1};
      checks++;
      if (ce !== exp) begin
        failures++;
        $display("FAIL div_ce k=%0d: ce=%b required %b", k, ce, exp);
      end
`ifdef CLK_EN_GEN_SQ_EN
      checks++;
      if (sq[1] !== ((k / 2) % 2 == 1)) begin
        failures++;
        $display("FAIL sq1 k=%0d: sq1=%b required %b", k, sq[1], ((k / 2) % 2 == 1));
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_div_change();
    logic [3:0] exp_ce;
    logic [3:0] exp_ack;
    do_reset(1'b0);
    write_idle(1, 16'd9);
    write_idle(2, 16'd3);
    locked = 1'b1;
    wait_ready();
    for (int k = 0; k <= 21; k++) begin
      exp_ce  = {1'b1, (k % 4) == 3, (k == 9 || k == 14 || k == 17 || k == 20), 1'b1};
      exp_ack = (k == 9 || k == 14) ? 4'b0010 : 4'b0000;
      checks++;
      if (ce !== exp_ce) begin
        failures++;
        $display("FAIL change_ce k=%0d: ce=%b required %b", k, ce, exp_ce);
      end
      checks++;
      if (div_ack !== exp_ack) begin
        failures++;
        $display("FAIL change_ack k=%0d: div_ack=%b required %b", k, div_ack, exp_ack);
      end
      div_wr = (k == 3 || k == 9);
      div_sel = 2'd1;
      div_val = (k == 3) ? 16'd4 : 16'd2;
      @(negedge clk);
    end
    div_wr = 1'b0;
  endtask

  task automatic test_lock_drop();
    locked = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if (ready !== (n < 3)) begin
        failures++;
        $display("FAIL drop edge %0d: ready=%b required %b", n, ready, (n < 3));
      end
    end
    checks++;
    if ({sys_rst, ce} !== {1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL drop_out: sys_rst=%b ce=%b required 1 0000", sys_rst, ce);
    end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_glitch();
    test_div();
    test_div_change();
    test_lock_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of clock-enable channels, 1..8.
REQ-002 SHALL have parameter CNT_W, default 16: divisor and counter width.
REQ-003 SHALL have parameter LOCK_WAIT, default 16: cycles `locked` must stay high before run, at least 1.
REQ-004 SHALL have parameter DEF_DIV, default 0: reset divisor for every channel.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port locked, input, 1 bit: asynchronous clock-generator lock status.
REQ-008 SHALL have port div_wr, input, 1 bit: one-cycle divisor write strobe.
REQ-009 SHALL have port div_sel, input, $clog2(NUM_CH) bits, minimum 1: channel to write.
REQ-010 SHALL have port div_val, input, CNT_W bits: new divisor; period is div_val+1 cycles.
REQ-011 SHALL have port div_ack, output, NUM_CH bits: per-channel one-cycle pulse when the new divisor takes effect.
REQ-012 SHALL have port ce, output, NUM_CH bits: per-channel one-cycle clock-enable pulses.
REQ-013 SHALL have port ready, output, 1 bit: high while in RUN.
REQ-014 SHALL have port sys_rst, output, 1 bit: synchronous active-high reset for downstream logic, equal to ~ready.

Function
REQ-015 SHALL pass `locked` through a 2-flop synchroniser (lock_s) before any use.
REQ-016 SHALL implement the FSM states HOLD, WAIT_LOCK, STABLE and RUN.
REQ-017 SHALL sequence the FSM as follows: HOLD -> WAIT_LOCK after one cycle; WAIT_LOCK -> STABLE when lock_s=1.
REQ-018 SHALL, in STABLE, count lock_s-high cycles; lock_s=0 returns to WAIT_LOCK with the count cleared; count = LOCK_WAIT-1 -> RUN.
REQ-019 SHALL, in RUN, transition lock_s=0 -> WAIT_LOCK on the next edge; ready falls and all counters clear on that edge.
REQ-020 SHALL, in RUN, increment each channel counter every cycle; at counter == div, assert ce for that cycle and wrap the counter to 0.
REQ-021 SHALL treat div=0 as ce constantly high in RUN; div = 2^CNT_W-1 gives period 2^CNT_W, with no overflow beyond the wrap.
REQ-022 SHALL hold ce low and counters at 0 outside RUN; the first ce occurs div+1 cycles after ready rises.
REQ-023 SHALL latch div_val into the pending register of channel div_sel and set its pending flag on div_wr; div_sel >= NUM_CH SHALL be ignored.
REQ-024 SHALL apply a pending divisor on the cycle that channel wraps (ce high); from the next cycle the counter uses the new divisor, and div_ack pulses in the same cycle as that ce.
REQ-025 SHALL apply a pending divisor immediately, with div_ack, when outside RUN.
REQ-026 SHALL let a second write to a channel while pending overwrite the pending value; only one div_ack is produced.
REQ-027 SHALL, when div_wr coincides with the apply cycle of the same channel, apply the old pending value and make the new value pending.
REQ-028 SHALL NOT let a write to one channel disturb the phase of other channels.

Reset
REQ-029 SHALL, on rst, asynchronously set: FSM=HOLD, ready=0, sys_rst=1, ce=0, div_ack=0, counters=0, divisors=DEF_DIV, pending flags=0, synchroniser=0, stable count=0.
REQ-030 SHALL abort a mid-operation rst immediately, discarding pending writes; after release, HOLD is entered for exactly one cycle.

Configuration
REQ-031 SHALL, with macro CLK_EN_GEN_SQ_EN defined, add output sq[NUM_CH], reset 0, toggling each cycle the channel's ce is high and forced to 0 outside RUN; div=0 then gives clk/2.
REQ-032 SHALL, without CLK_EN_GEN_SQ_EN defined, have no sq port and no toggle flops.

Structure
REQ-033 SHALL place the FSM state enum and the localparam SYNC_STAGES=2 in package clk_en_gen_pkg.
REQ-034 SHALL implement the per-channel counter, divisor and pending logic as sub-module clk_en_chan, instantiated NUM_CH times via generate.

Verification
REQ-035 SHALL cover locked=1 from the reset release, LOCK_WAIT=16 -> ready rises exactly 1+2+16 cycles after the rst deassert edge, per the HOLD/sync/STABLE sequence.
REQ-036 SHALL cover lock glitching low for 1 cycle at STABLE count 10 -> the count restarts, and ready is delayed accordingly.
REQ-037 SHALL cover div=0, 1, 3 on ch0..2 -> ce periods of 1, 2 and 4 cycles; the first ch2 ce arrives 4 cycles after ready.
REQ-038 SHALL cover ch1 div=9 with a write of div_val=4 at counter 3 -> ce at counter 9, div_ack in the same cycle, then period 5; other channels unperturbed.
REQ-039 SHALL cover locked dropping in RUN -> ready=0 and ce=0 within 3 cycles (sync+1), and sys_rst=1.
REQ-040 SHALL cover CLK_EN_GEN_SQ_EN with div=1 -> sq period 4 cycles at 50% duty.
